// File: rtl/ex_sm_pkg.sv
// ex_sm_pkg: shared defaults for the ex_sm input conditioner and its benches.
//   SYNC_STAGES_DEF     - default synchroniser depth per channel
//   DEBOUNCE_CYCLES_DEF - default number of edges a new value must persist
//   cnt_width()         - width of a debounce counter able to hold 0..cycles
//   abc_t               - the three ex_sm inputs bundled as one payload
package ex_sm_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  // Counter width for a count that must reach cycles-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(cycles) + 64'd1) w = w + 1;
    return w;
  endfunction

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } abc_t;

endpackage

// File: rtl/ex_sm_input_cond_debounce_ch.sv
// debounce_ch: one input-conditioner channel.
//   Synchronises an asynchronous raw input, debounces it with a stability
//   counter and emits the clean level plus a one-cycle rising-edge pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   raw  - asynchronous, possibly bouncing input
//   lvl  - debounced level (registered)
//   rise - one-cycle pulse after lvl goes 0->1 (registered)
module debounce_ch
  import ex_sm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   lvl_d;
  logic                   rise_d;

  assign s = sync_q[SYNC_STAGES-1];

  // State registers: synchroniser chain, counter, level and pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl    <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q  <= cnt_d;
      lvl    <= lvl_d;
      rise   <= rise_d;
    end
  end

  // Next state: any return of s to lvl restarts the count; a full count
  // of disagreeing edges accepts the new value.
  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl;
    rise_d = 1'b0;
    if (s != lvl) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d  = s;
        rise_d = s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ex_sm_input_cond.sv
// ex_sm_input_cond: three-channel input conditioner feeding ex_sm a/b/c.
//   Each raw input is synchronised and debounced independently.
// Ports:
//   clk                    - rising-edge clock
//   rst                    - synchronous active-low reset
//   raw_a, raw_b, raw_c    - asynchronous, bouncing raw inputs
//   a, b, c                - debounced levels to ex_sm (registered)
//   a_rise, b_rise, c_rise - one-cycle rising-edge pulses (registered)
module ex_sm_input_cond
  import ex_sm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_c,
  output logic a,
  output logic b,
  output logic c,
  output logic a_rise,
  output logic b_rise,
  output logic c_rise
);

  abc_t raw_v;
  abc_t lvl_v;
  abc_t rise_v;

  assign raw_v = '{a: raw_a, b: raw_b, c: raw_c};

  assign a      = lvl_v.a;
  assign b      = lvl_v.b;
  assign c      = lvl_v.c;
  assign a_rise = rise_v.a;
  assign b_rise = rise_v.b;
  assign c_rise = rise_v.c;

  // Three identical, independent channels.
  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_a (
    .clk (clk),
    .rst (rst),
    .raw (raw_v.a),
    .lvl (lvl_v.a),
    .rise(rise_v.a)
  );

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_b (
    .clk (clk),
    .rst (rst),
    .raw (raw_v.b),
    .lvl (lvl_v.b),
    .rise(rise_v.b)
  );

  debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_c (
    .clk (clk),
    .rst (rst),
    .raw (raw_v.c),
    .lvl (lvl_v.c),
    .rise(rise_v.c)
  );

endmodule
